sqrt_initiator: RTL
===================

# sqrt_initiator

Request sequencer for the 16-bit integer square-root core. It accepts operands on a valid/ready request port and drives the core's `start`/`data_in` side. It waits for the core's `done` and returns the 8-bit root on a valid/ready response port, with timeout and optional result-check flags. It sits between a host-side producer (UART/switch debouncer/test logic) and the `sqrt` core, replacing direct switch wiring.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before a transaction is aborted; legal range 2..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  operand offered.
- `req_ready`  out  1  block can accept an operand.
- `req_data`  in  16  operand.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_data`  out  16  operand to the core; held stable from ISSUE until the block leaves WAIT.
- `core_result`  in  8  core root output.
- `core_done`  in  1  core completion; level or pulse.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_root`  out  8  captured root.
- `rsp_timeout`  out  1  transaction aborted by timeout.
- `rsp_mismatch`  out  1  result failed the range check (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT, CHECK (only with the macro), RESP.
- **IDLE:** `req_ready`=1. When `req_valid`&`req_ready`, latch `req_data` into the operand register and go to ISSUE.
- **ISSUE:** `core_start`=1 for exactly this cycle. Clear the timer, then go to WAIT.
- **WAIT:** the timer increments each cycle.
  - Completion is a rising edge of `core_done` (`core_done` & ~`done_q`), where `done_q` is registered every cycle in all states. Stale `done` held high from a previous run is therefore never taken as completion.
  - On completion: capture `core_result`, then go to CHECK if present, else RESP.
  - If the timer equals `TIMEOUT_CYCLES`-1 with no completion: set `rsp_timeout`=1, `rsp_root`=0, go to RESP.
  - If completion and the timeout condition occur in the same cycle, completion wins.
- **CHECK:** with root r and operand x, compute r*r and (r+1)*(r+1) at 17 bits, unsigned. Set `rsp_mismatch` = ~(r*r ≤ x < (r+1)*(r+1)), then go to RESP. Never evaluated on a timeout.
- **RESP:** `rsp_valid`=1 and all `rsp_*` outputs held stable. On `rsp_ready`, go to IDLE and clear the flags. `req_ready`=0 in every state except IDLE.

## Timing
- Reset values: `req_ready`=0 while `rst` is high, then 1 from the first cycle after release. All other outputs reset to 0. The FSM resets to IDLE, and the timer, operand register and `done_q` reset to 0.
- Cycle numbering, counted from the request handshake in cycle 0:
  - ISSUE is cycle 1, with `core_start` high.
  - WAIT starts in cycle 2.
  - A done edge in cycle k gives `rsp_valid` at k+1 without the macro, or k+2 with it.
- Timeout: WAIT lasts at most `TIMEOUT_CYCLES` cycles. On timeout `rsp_valid` rises at cycle 2+`TIMEOUT_CYCLES`.
- `rsp_valid` does not depend combinationally on `rsp_ready`. `req_ready` is registered state only.
- Reset mid-operation (any state): outputs return to reset values asynchronously and any response is dropped. The core shares the reset, so no stale transaction survives.
- No back-to-back bypass: the minimum period between accepted requests is 4 cycles without the macro, 5 with it, plus the core latency.

## Configuration
- `SQRT_INITIATOR_CHECK_EN` defined: the CHECK state and range checker are built, and `rsp_mismatch` is live.
- Not defined: no CHECK state, so WAIT goes directly to RESP. `rsp_mismatch` is tied to 0 and there are no multipliers.

## Structure
- Shared package `sqrt_pkg` holds:
  - `SQRT_OPERAND_W`=16 and `SQRT_ROOT_W`=8;
  - the FSM state enum `sqrt_init_state_t`;
  - a default timeout constant.
- One sub-module, `sqrt_range_check`: combinational, inputs x[15:0] and r[7:0], output `ok`. It is instantiated only under the macro.

## Test plan
- Behavioural core model (done 9 cycles after start), request 144: one `core_start` pulse, `core_data`=144; response root=12, timeout=0, mismatch=0, `rsp_valid` 11 cycles after the handshake without the macro.
- Requests 0 and 16'hFFFF: roots 0 and 255, no flags; with the macro, mismatch=0 for both (checks the 17-bit boundary).
- Core model never asserts done, `TIMEOUT_CYCLES`=64: `rsp_valid` at cycle 66 with timeout=1 and root=0. A following request 49 with a working core returns 7.
- Core holds `done` high until the next start, with back-to-back requests 25 then 36: the second response is 6, not the stale 5.
- `rsp_ready` held low 10 cycles: response stable, `req_ready`=0, a second `req_valid` is not accepted until the response is taken.
- With the macro, the model returns 13 for 144: mismatch=1. `rst` pulsed during WAIT: `rsp_valid`/`core_start`=0 immediately, `req_ready`=1 one cycle after release, and the next request completes normally.

Source files
------------

// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sqrt_pkg
// Purpose : Shared widths, FSM state type and default timeout for the
//           sqrt_initiator request sequencer and its range checker.
// Contents: SQRT_OPERAND_W, SQRT_ROOT_W, SQRT_DEFAULT_TIMEOUT,
//           sqrt_init_state_t
// Revision: 1.0 - initial release
// ============================================================================
package sqrt_pkg;

  localparam int SQRT_OPERAND_W       = 16;
  localparam int SQRT_ROOT_W          = 8;
  localparam int SQRT_DEFAULT_TIMEOUT = 64;

  // ST_CHECK is only reachable when SQRT_INITIATOR_CHECK_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RESP  = 3'd4
  } sqrt_init_state_t;

endpackage : sqrt_pkg
`default_nettype wire

// File: rtl/sqrt_range_check.sv
`default_nettype none
// ============================================================================
// Module  : sqrt_range_check
// Purpose : Combinational check that r is the integer square root of x,
//           i.e. r*r <= x < (r+1)*(r+1), evaluated at 17 bits unsigned so
//           that r=255 / x=16'hFFFF does not overflow.
// Ports   : x_i  [15:0] operand
//           r_i  [7:0]  candidate root
//           ok_o        1 when r_i is the floor square root of x_i
// Revision: 1.0 - initial release
// ============================================================================
module sqrt_range_check
  import sqrt_pkg::*;
(
  input  logic [SQRT_OPERAND_W-1:0] x_i,
  input  logic [SQRT_ROOT_W-1:0]    r_i,
  output logic                      ok_o
);

  logic [SQRT_ROOT_W:0]      w_r_plus1;
  logic [SQRT_OPERAND_W:0]   w_sq_lo;
  logic [SQRT_OPERAND_W:0]   w_sq_hi;
  logic [SQRT_OPERAND_W:0]   w_x_ext;

  assign w_r_plus1 = {1'b0, r_i} + 9'd1;
  assign w_sq_lo   = {9'd0, r_i} * {9'd0, r_i};
  assign w_sq_hi   = {8'd0, w_r_plus1} * {8'd0, w_r_plus1};
  assign w_x_ext   = {1'b0, x_i};

  assign ok_o = (w_sq_lo <= w_x_ext) && (w_x_ext < w_sq_hi);

endmodule : sqrt_range_check
`default_nettype wire

// File: rtl/sqrt_initiator.sv
`default_nettype none
// ============================================================================
// Module  : sqrt_initiator
// Purpose : Request sequencer for the 16-bit integer square-root core.
//           Accepts an operand on a valid/ready request port, pulses the
//           core start, waits for a rising edge of core_done (or a timeout)
//           and returns the root on a valid/ready response port.
// Macro   : SQRT_INITIATOR_CHECK_EN - builds the CHECK state and the range
//           checker; otherwise rsp_mismatch_o is tied to 0.
// Ports   : clk_i, rst_i (async, active high)
//           req_valid_i / req_ready_o / req_data_i[15:0]  request port
//           core_start_o, core_data_o[15:0]                core drive
//           core_result_i[7:0], core_done_i                core return
//           rsp_valid_o / rsp_ready_i, rsp_root_o[7:0],
//           rsp_timeout_o, rsp_mismatch_o                  response port
// Revision: 1.0 - initial release
// ============================================================================
module sqrt_initiator
  import sqrt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SQRT_DEFAULT_TIMEOUT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [SQRT_OPERAND_W-1:0] req_data_i,
  output logic                      core_start_o,
  output logic [SQRT_OPERAND_W-1:0] core_data_o,
  input  logic [SQRT_ROOT_W-1:0]    core_result_i,
  input  logic                      core_done_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [SQRT_ROOT_W-1:0]    rsp_root_o,
  output logic                      rsp_timeout_o,
  output logic                      rsp_mismatch_o
);

  // Last timer value allowed in WAIT; reaching it without completion aborts.
  localparam logic [15:0] C_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  sqrt_init_state_t          state_q, state_d;
  logic [SQRT_OPERAND_W-1:0] operand_q, operand_d;
  logic [15:0]               timer_q, timer_d;
  logic [SQRT_ROOT_W-1:0]    root_q, root_d;
  logic                      timeout_q, timeout_d;
  logic                      req_ready_q;
  logic                      done_q;
  logic                      w_done_edge;

  // A done level left high by a previous run never counts as completion.
  assign w_done_edge = core_done_i & ~done_q;

`ifdef SQRT_INITIATOR_CHECK_EN
  logic mismatch_q, mismatch_d;
  logic w_range_ok;

  sqrt_range_check u_range_check (
    .x_i  (operand_q),
    .r_i  (root_q),
    .ok_o (w_range_ok)
  );
`endif

  always_comb begin
    state_d    = state_q;
    operand_d  = operand_q;
    timer_d    = timer_q;
    root_d     = root_q;
    timeout_d  = timeout_q;
`ifdef SQRT_INITIATOR_CHECK_EN
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          operand_d = req_data_i;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 16'd1;
        // Completion takes priority over a simultaneous timeout.
        if (w_done_edge) begin
          root_d = core_result_i;
`ifdef SQRT_INITIATOR_CHECK_EN
          state_d = ST_CHECK;
`else
          state_d = ST_RESP;
`endif
        end else if (timer_q == C_TIMER_LAST) begin
          timeout_d = 1'b1;
          root_d    = '0;
          state_d   = ST_RESP;
        end
      end
`ifdef SQRT_INITIATOR_CHECK_EN
      ST_CHECK: begin
        mismatch_d = ~w_range_ok;
        state_d    = ST_RESP;
      end
`endif
      ST_RESP: begin
        if (rsp_ready_i) begin
          timeout_d = 1'b0;
`ifdef SQRT_INITIATOR_CHECK_EN
          mismatch_d = 1'b0;
`endif
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      operand_q   <= '0;
      timer_q     <= '0;
      root_q      <= '0;
      timeout_q   <= 1'b0;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      timer_q     <= timer_d;
      root_q      <= root_d;
      timeout_q   <= timeout_d;
      // Registered copy of "next state is IDLE" so req_ready is a flop
      // and stays low during reset.
      req_ready_q <= (state_d == ST_IDLE);
      done_q      <= core_done_i;
    end
  end

`ifdef SQRT_INITIATOR_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end
  assign rsp_mismatch_o = mismatch_q;
`else
  assign rsp_mismatch_o = 1'b0;
`endif

  assign req_ready_o   = req_ready_q;
  assign core_start_o  = (state_q == ST_ISSUE);
  assign core_data_o   = operand_q;
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign rsp_root_o    = root_q;
  assign rsp_timeout_o = timeout_q;

endmodule : sqrt_initiator
`default_nettype wire
